// File: rtl/gb_audio_i2s_tx.sv
// gb_audio_i2s_tx: serializes the 16-bit mono APU output into an I2S stream.
// A one-entry holding buffer takes samples over valid/ready. The frame
// timing (BCLK divider, 32-slot frame, word select) is owned here. When no
// new sample is buffered at a frame boundary, the previous word repeats.
module gb_audio_i2s_tx #(
    parameter int BCLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    // Divider and frame position
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               bclk_q, bclk_d;
    logic [4:0]         slot_q, slot_d;

    // Serial outputs, registered so they only move with the BCLK falling edge
    logic               lrclk_q, lrclk_d;
    logic               sdata_q, sdata_d;
    logic               underrun_q, underrun_d;

    // Holding buffer and the word currently being shifted out
    logic               hold_full_q, hold_full_d;
    logic signed [15:0] hold_word_q, hold_word_d;
    logic signed [15:0] frame_word_q, frame_word_d;

    logic               clear;
    logic               accept;
    logic               div_wrap;
    logic               bclk_fall;
    logic               frame_load;

    // APU samples are offset binary; the DAC expects two's complement.
    function automatic logic signed [15:0] to_twos(input logic [15:0] s);
        return signed'(s ^ 16'h8000);
    endfunction

    // Word select leads each channel's MSB by one bit clock.
    function automatic logic lr_for_slot(input logic [4:0] s);
        return (s >= 5'd15) && (s <= 5'd30);
    endfunction

    // Same word in both halves of the frame, MSB first.
    function automatic logic bit_for_slot(input logic [15:0] w, input logic [4:0] s);
        return w[4'd15 - s[3:0]];
    endfunction

    assign clear        = reset || !enable;
    assign sample_ready = enable && !hold_full_q;
    assign accept       = sample_valid && sample_ready;

    assign div_wrap     = (div_cnt_q == DIV_LAST);
    assign bclk_fall    = div_wrap && bclk_q;
    assign frame_load   = bclk_fall && (slot_q == 5'd31);

    assign i2s_bclk     = bclk_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_sdata    = sdata_q;
    assign underrun     = underrun_q;

    // Next-state: divider, slot advance on BCLK fall, buffer handoff at frame load
    always_comb begin
        div_cnt_d    = div_wrap ? '0 : div_cnt_q + 1'b1;
        bclk_d       = div_wrap ? !bclk_q : bclk_q;
        slot_d       = slot_q;
        lrclk_d      = lrclk_q;
        sdata_d      = sdata_q;
        hold_full_d  = hold_full_q;
        hold_word_d  = hold_word_q;
        frame_word_d = frame_word_q;

        // The load looks at the buffer as it stood before this cycle, so a
        // sample arriving in the load cycle waits for the next frame.
        underrun_d   = frame_load && !hold_full_q;

        if (frame_load && hold_full_q) begin
            frame_word_d = hold_word_q;
            hold_full_d  = 1'b0;
        end else if (accept) begin
            hold_full_d  = 1'b1;
        end

        if (accept) begin
            hold_word_d = to_twos(sample_in);
        end

        if (bclk_fall) begin
            slot_d  = slot_q + 5'd1;
            lrclk_d = lr_for_slot(slot_d);
            sdata_d = bit_for_slot(frame_word_d, slot_d);
        end
    end

    // Control and output state; reset or enable low aborts the frame at once
    always_ff @(posedge clk) begin
        if (clear) begin
            div_cnt_q    <= '0;
            bclk_q       <= 1'b0;
            slot_q       <= 5'd31;
            lrclk_q      <= 1'b0;
            sdata_q      <= 1'b0;
            underrun_q   <= 1'b0;
            hold_full_q  <= 1'b0;
            frame_word_q <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bclk_q       <= bclk_d;
            slot_q       <= slot_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            underrun_q   <= underrun_d;
            hold_full_q  <= hold_full_d;
            frame_word_q <= frame_word_d;
        end
    end

    // Buffered sample data; only meaningful while hold_full_q is set
    always_ff @(posedge clk) begin
        hold_word_q <= hold_word_d;
    end

endmodule
